// File: rtl/dcpu16_marb_if.sv
// dcpu16_marb_if: simplified-Wishbone port; adr/stb/wre/dto flow master->slave, dti/ack slave->master
interface dcpu16_marb_if;
    logic [15:0] adr;
    logic        stb;
    logic        wre;
    logic [15:0] dto;
    logic [15:0] dti;
    logic        ack;
    modport master (output adr, stb, wre, dto, input dti, ack);
    modport slave  (input adr, stb, wre, dto, output dti, ack);
endinterface

// File: rtl/dcpu16_marb.sv
// dcpu16_marb: F/G bus arbiter onto one memory port with timeout; DCPU16_MARB_RR_EN selects round-robin arbitration
module dcpu16_marb #(
    parameter int TMO   = 16,
    parameter int TMO_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    dcpu16_marb_if.slave  f,
    dcpu16_marb_if.slave  g,
    dcpu16_marb_if.master m,
    output logic          bus_err
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] RETIRE = 2'd2;

    logic [1:0]       state;
    logic [TMO_W-1:0] cnt;
    logic [15:0]      dat;
    logic             gnt;
    logic             pick_g;

`ifdef DCPU16_MARB_RR_EN
    logic ptr;
    assign pick_g = g.stb && (!f.stb || ptr);
    // priority pointer: after each grant, the other master gets priority on a tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 1'b0;
        else if (state == IDLE && (f.stb || g.stb))
            ptr <= !pick_g;
    end
`else
    assign pick_g = g.stb && !f.stb;
`endif

    // request capture, memory access with timeout, and ack to the granted master
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            dat     <= '0;
            gnt     <= 1'b0;
            bus_err <= 1'b0;
            m.adr   <= '0;
            m.stb   <= 1'b0;
            m.wre   <= 1'b0;
            m.dto   <= '0;
            f.dti   <= '0;
            f.ack   <= 1'b0;
            g.dti   <= '0;
            g.ack   <= 1'b0;
        end else begin
            f.ack <= 1'b0;
            g.ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (f.stb || g.stb) begin
                        gnt   <= pick_g;
                        m.adr <= pick_g ? g.adr : f.adr;
                        m.wre <= pick_g ? g.wre : f.wre;
                        m.dto <= pick_g ? g.dto : f.dto;
                        m.stb <= 1'b1;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (m.ack) begin
                        dat   <= m.wre ? 16'h0000 : m.dti;
                        m.stb <= 1'b0;
                        state <= RETIRE;
                    end else if (cnt == TMO_W'(TMO - 1)) begin
                        dat     <= 16'hFFFF;
                        bus_err <= 1'b1;
                        m.stb   <= 1'b0;
                        state   <= RETIRE;
                    end else begin
                        cnt <= cnt + TMO_W'(1);
                    end
                end
                RETIRE: begin
                    if (gnt) begin
                        g.ack <= 1'b1;
                        g.dti <= dat;
                    end else begin
                        f.ack <= 1'b1;
                        f.dti <= dat;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcpu16_marb.sv
// tb_dcpu16_marb: directed self-checking bench for dcpu16_marb
module tb_dcpu16_marb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bus_err;
    int   cmps = 0;
    int   errs = 0;

    dcpu16_marb_if f_if ();
    dcpu16_marb_if g_if ();
    dcpu16_marb_if m_if ();

    dcpu16_marb #(.TMO(16), .TMO_W(8)) dut (
        .clk(clk), .rst(rst), .f(f_if), .g(g_if), .m(m_if), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        f_if.adr = '0; f_if.stb = 0; f_if.wre = 0; f_if.dto = '0;
        g_if.adr = '0; g_if.stb = 0; g_if.wre = 0; g_if.dto = '0;
        m_if.dti = '0; m_if.ack = 0;
        tick(); tick();
        chk("rst_mstb", m_if.stb, 0);
        chk("rst_fack", f_if.ack, 0);
        chk("rst_gack", g_if.ack, 0);
        chk("rst_err", bus_err, 0);
        chk("rst_madr", m_if.adr, 0);
        rst = 0;
        tick();
        // single F read, zero-wait memory
        f_if.adr = 16'h0010; f_if.stb = 1; m_if.dti = 16'h7C01; m_if.ack = 1;
        tick();
        chk("f1_mstb", m_if.stb, 1);
        chk("f1_madr", m_if.adr, 16'h0010);
        chk("f1_mwre", m_if.wre, 0);
        chk("f1_fack_early", f_if.ack, 0);
        tick();
        chk("f1_mstb_drop", m_if.stb, 0);
        chk("f1_fack_early2", f_if.ack, 0);
        tick();
        chk("f1_fack", f_if.ack, 1);
        chk("f1_fdti", f_if.dti, 16'h7C01);
        chk("f1_gack", g_if.ack, 0);
        f_if.stb = 0;
        tick();
        chk("f1_fack_pulse", f_if.ack, 0);
        chk("f1_idle_mstb", m_if.stb, 0);
        // G write with 2 wait states
        m_if.ack = 0;
        g_if.adr = 16'h8000; g_if.dto = 16'hBEEF; g_if.wre = 1; g_if.stb = 1;
        tick();
        chk("g2_mstb0", m_if.stb, 1);
        chk("g2_madr", m_if.adr, 16'h8000);
        chk("g2_mwre", m_if.wre, 1);
        chk("g2_mdto", m_if.dto, 16'hBEEF);
        tick();
        chk("g2_mstb1", m_if.stb, 1);
        tick();
        chk("g2_mstb2", m_if.stb, 1);
        chk("g2_mdto2", m_if.dto, 16'hBEEF);
        chk("g2_madr2", m_if.adr, 16'h8000);
        m_if.ack = 1;
        tick();
        m_if.ack = 0;
        chk("g2_mstb_drop", m_if.stb, 0);
        chk("g2_gack_early", g_if.ack, 0);
        tick();
        chk("g2_gack", g_if.ack, 1);
        chk("g2_gdti", g_if.dti, 16'h0000);
        chk("g2_fack", f_if.ack, 0);
        chk("g2_fdti_hold", f_if.dti, 16'h7C01);
        g_if.stb = 0; g_if.wre = 0;
        tick();
        // simultaneous requests: F first, G next
        f_if.adr = 16'h0100; f_if.stb = 1; g_if.adr = 16'h0200; g_if.stb = 1;
        m_if.ack = 1; m_if.dti = 16'h1111;
        tick();
        chk("sim_madr_f", m_if.adr, 16'h0100);
        tick(); tick();
        chk("sim_fack", f_if.ack, 1);
        chk("sim_gack0", g_if.ack, 0);
        chk("sim_fdti", f_if.dti, 16'h1111);
        f_if.stb = 0; m_if.dti = 16'h2222;
        tick();
        chk("sim_madr_g", m_if.adr, 16'h0200);
        chk("sim_fack_off", f_if.ack, 0);
        tick(); tick();
        chk("sim_gack", g_if.ack, 1);
        chk("sim_gdti", g_if.dti, 16'h2222);
        g_if.stb = 0;
        tick();
        // both held high for four grants: fixed priority repeats F, round-robin alternates
        f_if.adr = 16'h0300; f_if.stb = 1; g_if.adr = 16'h0400; g_if.stb = 1;
        for (int k = 0; k < 4; k++) begin
`ifdef DCPU16_MARB_RR_EN
            logic exp_g = k[0];
`else
            logic exp_g = 1'b0;
`endif
            tick();
            chk($sformatf("arb%0d_madr", k), m_if.adr, exp_g ? 16'h0400 : 16'h0300);
            tick(); tick();
            chk($sformatf("arb%0d_fack", k), f_if.ack, !exp_g);
            chk($sformatf("arb%0d_gack", k), g_if.ack, exp_g);
        end
        f_if.stb = 0; g_if.stb = 0;
        tick();
        // timeout: no m_ack for 16 BUSY cycles
        m_if.ack = 0; f_if.adr = 16'h0500; f_if.stb = 1;
        tick();
        chk("to_mstb0", m_if.stb, 1);
        chk("to_err0", bus_err, 0);
        for (int k = 0; k < 15; k++) tick();
        chk("to_mstb15", m_if.stb, 1);
        chk("to_err15", bus_err, 0);
        tick();
        chk("to_mstb_drop", m_if.stb, 0);
        chk("to_err", bus_err, 1);
        chk("to_fack_early", f_if.ack, 0);
        tick();
        chk("to_fack", f_if.ack, 1);
        chk("to_fdti", f_if.dti, 16'hFFFF);
        f_if.stb = 0;
        m_if.ack = 1; m_if.dti = 16'h1234; g_if.adr = 16'h0600; g_if.stb = 1;
        tick(); tick(); tick();
        chk("to_good_gack", g_if.ack, 1);
        chk("to_good_gdti", g_if.dti, 16'h1234);
        chk("to_err_sticky", bus_err, 1);
        g_if.stb = 0;
        tick();
        // asynchronous reset mid-BUSY
        m_if.ack = 0; f_if.adr = 16'h0700; f_if.stb = 1;
        tick(); tick();
        chk("ar_busy", m_if.stb, 1);
        #2 rst = 1;
        #1;
        chk("ar_mstb", m_if.stb, 0);
        chk("ar_err", bus_err, 0);
        chk("ar_fack", f_if.ack, 0);
        chk("ar_gack", g_if.ack, 0);
        chk("ar_madr", m_if.adr, 0);
        f_if.stb = 0;
        tick();
        rst = 0;
        // restart from IDLE, then back-to-back F reads with f_stb held
        f_if.adr = 16'h0800; f_if.stb = 1; m_if.ack = 1; m_if.dti = 16'hABCD;
        tick();
        chk("rs_mstb", m_if.stb, 1);
        chk("rs_madr", m_if.adr, 16'h0800);
        tick(); tick();
        chk("bb_fack1", f_if.ack, 1);
        chk("bb_fdti1", f_if.dti, 16'hABCD);
        f_if.adr = 16'h0900; m_if.dti = 16'h5555;
        tick();
        chk("bb_mstb2", m_if.stb, 1);
        chk("bb_madr2", m_if.adr, 16'h0900);
        chk("bb_fack_off", f_if.ack, 0);
        tick();
        chk("bb_mid_fack", f_if.ack, 0);
        tick();
        chk("bb_fack2", f_if.ack, 1);
        chk("bb_fdti2", f_if.dti, 16'h5555);
        f_if.stb = 0;
        tick();
        chk("bb_no_dup", f_if.ack, 0);
        chk("bb_idle", m_if.stb, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
